// File: rtl/weight_mac_unit.sv
// Fetches a signed weight by index, multiplies it by an unsigned pixel and accumulates into acc.
// Latency: FETCH, MEM_LAT wait cycles, MAC; acc changes on the edge that ends the MAC state.
// Backpressure: none; a start while busy is dropped and flagged as a sticky overrun.
module weight_mac_unit #(
    parameter int IDX_W   = 13,
    parameter int W_W     = 16,
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] weight_index,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [IDX_W-1:0] mem_address,
    output logic             mem_read,
    input  logic [W_W-1:0]   mem_readdata
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int PROD_W = W_W + PIX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_MAC   = 2'd3
    } state_t;

    state_t                   state;
    logic [LAT_W-1:0]         lat_cnt;
    logic [PIX_W-1:0]         pixel_q;
    logic signed [W_W-1:0]    w_q;
    logic [ACC_W-1:0]         acc;
    logic [15:0]              mac_count;
    logic                     done;
    logic                     overrun;

    logic                     wr;
    logic                     start;
    logic                     clear;
    logic                     busy;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic                     unused_wdata;

    assign wr    = chipselect & ~write_n;
    assign start = wr && (address == 2'd1);
    assign clear = wr && (address == 2'd3);
    assign busy  = (state != S_IDLE);

    // Pixel gets a zero MSB so the multiply stays signed without reinterpreting it.
    assign prod     = w_q * $signed({1'b0, pixel_q});
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    assign unused_wdata = ^writedata[31:PIX_W];

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = 32'(acc);
            2'd2:    readdata = {29'd0, overrun, done, busy};
            2'd3:    readdata = {16'd0, mac_count};
            default: readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            pixel_q     <= '0;
            w_q         <= '0;
            acc         <= '0;
            mac_count   <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            mem_read <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pixel_q     <= writedata[PIX_W-1:0];
                        mem_address <= weight_index;
                        mem_read    <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state   <= S_WAIT;
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        w_q   <= $signed(mem_readdata);
                        state <= S_MAC;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_MAC: begin
                    acc       <= acc + prod_ext;
                    mac_count <= mac_count + 16'd1;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (start && busy) begin
                overrun <= 1'b1;
            end

            // Clear overrides any update made above in the same cycle, including MAC.
            if (clear) begin
                acc       <= '0;
                mac_count <= '0;
                done      <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule
